// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path
package uart_pkg;
    localparam int OVERSAMPLE = 16;
    localparam int MIDSAMPLE  = 7;
    typedef logic [7:0] byte_t;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular receive byte buffer with combinational head output
//   clk, reset : clock, synchronous active-high reset
//   push/wdata : write a byte (ignored when full unless popped in the same cycle)
//   pop        : drop the head byte (ignored when empty)
//   rdata      : head byte; count/full/empty : occupancy
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    byte_t           mem [DEPTH];
    logic [AW-1:0]   wp, rp;
    logic            do_push, do_pop;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    // a full buffer still accepts a byte when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rp];

    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= wdata;
                wp      <= wp + 1'b1;
            end
            if (do_pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: 16x-oversampled 8N1 UART receiver with byte FIFO and status flags
//   clk, reset  : clock, synchronous active-high reset
//   enable      : receiver enable; low holds the FSM idle
//   bauddiv     : one sample tick every bauddiv+1 clocks
//   rx          : asynchronous serial input, idles high
//   rd, clrerr  : pop strobe, sticky-error clear strobe
//   rxdata/rxready/rxfull/fifocount : FIFO head and occupancy
//   frameerr/overrun : sticky error flags; rxbusy : frame in progress
//   UART_RX_PARITY_EN : adds parodd input, parerr sticky output and a parity bit
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [7:0]               bauddiv,
    input  logic                     rx,
    input  logic                     rd,
    input  logic                     clrerr,
`ifdef UART_RX_PARITY_EN
    input  logic                     parodd,
    output logic                     parerr,
`endif
    output logic [7:0]               rxdata,
    output logic                     rxready,
    output logic                     rxfull,
    output logic                     frameerr,
    output logic                     overrun,
    output logic                     rxbusy,
    output logic [$clog2(DEPTH):0]   fifocount
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] MID = SW'(MIDSAMPLE);

    rx_state_t       state, state_n;
    logic            rx_m, rxs;
    logic [7:0]      tcnt, div_q;
    logic [SW-1:0]   sc;
    logic [2:0]      bitcnt;
    byte_t           shreg;
    logic            tick, mid, push_q, empty, start_edge;

    // divisor is latched at each wrap so a change never shortens a running period
    assign tick       = tcnt == div_q;
    assign mid        = tick && sc == MID;
    assign start_edge = state == IDLE && !rxs;
    assign rxready    = !empty;
    assign rxbusy     = state != IDLE;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = rxs ? IDLE : START;
            START:   state_n = mid ? (rxs ? IDLE : DATA) : START;
`ifdef UART_RX_PARITY_EN
            DATA:    state_n = (mid && bitcnt == 3'd7) ? PARITY : DATA;
`else
            DATA:    state_n = (mid && bitcnt == 3'd7) ? STOP : DATA;
`endif
            PARITY:  state_n = mid ? STOP : PARITY;
            STOP:    state_n = mid ? (rxs ? IDLE : BREAK) : STOP;
            BREAK:   state_n = rxs ? IDLE : BREAK;
            default: state_n = IDLE;
        endcase
        if (!enable) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m     <= 1'b1;
            rxs      <= 1'b1;
            state    <= IDLE;
            tcnt     <= '0;
            div_q    <= '0;
            sc       <= '0;
            bitcnt   <= '0;
            shreg    <= '0;
            push_q   <= 1'b0;
            frameerr <= 1'b0;
            overrun  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parerr   <= 1'b0;
`endif
        end else begin
            rx_m     <= rx;
            rxs      <= rx_m;
            state    <= state_n;
            // byte lands in the FIFO one clock after the stop-bit sample
            push_q   <= enable && state == STOP && mid && rxs;
            frameerr <= (enable && state == STOP && mid && !rxs) || (frameerr && !clrerr);
            overrun  <= (push_q && rxfull && !rd) || (overrun && !clrerr);
`ifdef UART_RX_PARITY_EN
            parerr   <= (enable && state == PARITY && mid && ((^shreg ^ rxs) != parodd))
                        || (parerr && !clrerr);
`endif
            // frame start re-phases the bit clock to the falling edge
            if (!enable || start_edge) begin
                tcnt   <= '0;
                div_q  <= bauddiv;
                sc     <= '0;
                bitcnt <= '0;
            end else begin
                tcnt <= tick ? 8'd0 : tcnt + 8'd1;
                if (tick) div_q <= bauddiv;
                if (tick && state != IDLE) sc <= sc + 1'b1;
                if (state == DATA && mid) begin
                    shreg[bitcnt] <= rxs;
                    bitcnt        <= bitcnt + 3'd1;
                end
            end
        end
    end

    uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_q),
        .pop   (rd),
        .wdata (shreg),
        .rdata (rxdata),
        .count (fifocount),
        .full  (rxfull),
        .empty (empty)
    );
endmodule
